// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared constants for the execute stage of the 5-stage ARM pipeline:
//   - exe_cmd ALU opcode encodings
//   - operand-2 shift-type encodings
//   - NZCV bit positions inside the 4-bit status word
//   - a 32-bit rotate-right helper used by the operand-2 generator
// No ports (package).
// -----------------------------------------------------------------------------
package arm_pkg;

  // ALU opcodes carried in exe_cmd
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  // Shift types in shift_operand[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // NZCV bit indices (bit 3 = N ... bit 0 = V)
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate right by 0..31. A rotate of 0 leaves the value untouched because
  // the complementary left shift by 32 contributes nothing.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [5:0] back;
    back = 6'd32 - {1'b0, amt};
    return (x >> amt) | (x << back);
  endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// -----------------------------------------------------------------------------
// exe_mul_iter
// Iterative shift-and-add multiplier producing the low 32 bits of a*b.
// MUL_BITS multiplier bits are consumed per cycle (legal: 1, 2, 4, 8), so the
// BUSY phase lasts N = 32/MUL_BITS cycles.
//
// Sequence for one MUL:
//   IDLE (start seen, busy=1) -> BUSY x N (busy=1) -> DONE (busy=0, product
//   valid, done=1) -> IDLE.
//
// Handshake: start is a level, sampled only in IDLE. busy is the stall request
// to the pipeline: while busy=1 the caller keeps start/a/b steady, but the
// datapath works only from its own copies loaded at the IDLE->BUSY edge.
// A MUL still present on start during DONE is not restarted; the next one is
// only picked up once the FSM is back in IDLE.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset; forces IDLE and busy=0
//   start    in   a MUL instruction is present in EXE
//   a        in   multiplicand (operand 1)
//   b        in   multiplier (Rm value)
//   busy     out  stall request
//   done     out  high in the DONE cycle (product final)
//   product  out  accumulated product
// -----------------------------------------------------------------------------
module exe_mul_iter #(
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int         N    = 32 / MUL_BITS;
  localparam logic [5:0] LAST = 6'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  count;
  logic [31:0] partial;

  // Only the low 32 bits of the product are kept, so the multiplicand can be
  // shifted within 32 bits: bits pushed out the top never reach the result.
  assign partial = 32'(mplier[MUL_BITS-1:0]) * mcand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand   <= a;
            mplier  <= b;
            product <= '0;
            count   <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          product <= product + partial;
          mcand   <= mcand << MUL_BITS;
          mplier  <= mplier >> MUL_BITS;
          count   <= count + 6'd1;
          if (count == LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The IDLE term is combinational so the stall rises in the same cycle the
  // MUL arrives; rst masks it so a reset drops the stall immediately.
  assign busy = !rst && ((state == ST_BUSY) || ((state == ST_IDLE) && start));
  assign done = (state == ST_DONE);

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage ARM pipeline. Takes the registered decode
// bundle from ID/EX and produces the operand-2 value, the ALU result and the
// branch target, and owns the architectural NZCV register. MUL is executed by
// an iterative multiplier; while it runs, stall is raised so IF/ID and ID/EX
// hold and EX/MEM captures bubbles.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   exe_cmd        in   ALU opcode (see arm_pkg)
//   imm            in   operand 2 is a rotated 8-bit immediate
//   mem_r_en       in   load in EXE (operand 2 = 12-bit offset)
//   mem_w_en       in   store in EXE (operand 2 = 12-bit offset)
//   s              in   update flags
//   status_in      in   NZCV snapshot: ADC/SBC carry-in and C/V preservation
//   shift_operand  in   operand-2 encoding
//   signed_imm_24  in   branch word offset
//   pc             in   PC+4 of the instruction
//   val_rn         in   operand 1
//   val_rm         in   Rm value
//   alu_result     out  result (also the LDR/STR address)
//   br_addr        out  branch target
//   status_q       out  NZCV register
//   stall          out  multiplier busy
// -----------------------------------------------------------------------------
module exe_stage
  import arm_pkg::*;
#(
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  exe_cmd,
  input  logic        imm,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        s,
  input  logic [3:0]  status_in,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [31:0] pc,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  output logic [31:0] alu_result,
  output logic [31:0] br_addr,
  output logic [3:0]  status_q,
  output logic        stall
);

  logic [31:0] val2;
  logic [4:0]  shift_amt;
  logic [31:0] mul_product;
  logic        mul_done;

  // Arithmetic path: subtraction is done as rn + ~val2 + carry so the carry
  // out of bit 32 is directly ARM's NOT-borrow.
  logic [31:0] arith_op2;
  logic        arith_cin;
  logic [32:0] arith_sum;

  logic [31:0] result;
  logic        c_next;
  logic        v_next;
  logic        flag_write;

  // ---------------------------------------------------------------------------
  // Operand 2
  // ---------------------------------------------------------------------------
  assign shift_amt = shift_operand[11:7];

  always_comb begin
    val2 = '0;
    if (mem_r_en || mem_w_en) begin
      val2 = {20'b0, shift_operand};
    end else if (imm) begin
      val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << shift_amt;
        SH_LSR:  val2 = val_rm >> shift_amt;
        SH_ASR:  val2 = $signed(val_rm) >>> shift_amt;
        default: val2 = ror32(val_rm, shift_amt);
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier
  // ---------------------------------------------------------------------------
  exe_mul_iter #(
    .MUL_BITS(MUL_BITS)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (exe_cmd == CMD_MUL),
    .a      (val_rn),
    .b      (val_rm),
    .busy   (stall),
    .done   (mul_done),
    .product(mul_product)
  );

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    arith_op2 = val2;
    arith_cin = 1'b0;
    case (exe_cmd)
      CMD_ADC: arith_cin = status_in[FLAG_C];
      CMD_SUB: begin
        arith_op2 = ~val2;
        arith_cin = 1'b1;
      end
      CMD_SBC: begin
        arith_op2 = ~val2;
        arith_cin = status_in[FLAG_C];
      end
      default: begin
        arith_op2 = val2;
        arith_cin = 1'b0;
      end
    endcase
  end

  assign arith_sum = {1'b0, val_rn} + {1'b0, arith_op2} + {32'b0, arith_cin};

  always_comb begin
    result     = '0;
    c_next     = status_in[FLAG_C];
    v_next     = status_in[FLAG_V];
    flag_write = 1'b1;
    case (exe_cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        result = arith_sum[31:0];
        c_next = arith_sum[32];
        // Overflow: both addends share a sign that the sum does not.
        v_next = (val_rn[31] == arith_op2[31]) && (arith_sum[31] != val_rn[31]);
      end
      CMD_AND: result = val_rn & val2;
      CMD_ORR: result = val_rn | val2;
      CMD_EOR: result = val_rn ^ val2;
      CMD_MUL: begin
        result = mul_product;
        // The product is only final in DONE; earlier cycles are stalled anyway.
        flag_write = mul_done;
      end
      default: begin
        result     = '0;
        flag_write = 1'b0;
      end
    endcase
  end

  assign alu_result = result;

  // ---------------------------------------------------------------------------
  // Branch target: word offset, sign-extended, wraps modulo 2^32.
  // ---------------------------------------------------------------------------
  assign br_addr = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

  // ---------------------------------------------------------------------------
  // Status register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
    end else if (s && !stall && flag_write) begin
      status_q <= {result[31], (result == 32'd0), c_next, v_next};
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Self-checking bench for exe_stage: directed scenarios plus randomized ALU
// operations checked against a behavioural model, and multiplier timing,
// back-to-back and reset-abort scenarios.
// -----------------------------------------------------------------------------
module tb_exe_stage;
  import arm_pkg::*;

  localparam int MUL_BITS   = 1;
  localparam int MUL_STALLS = 32 / MUL_BITS + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic [3:0]  exe_cmd;
  logic        imm;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        s;
  logic [3:0]  status_in;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [31:0] pc;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [31:0] alu_result;
  logic [31:0] br_addr;
  logic [3:0]  status_q;
  logic        stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  exe_stage #(.MUL_BITS(MUL_BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .exe_cmd      (exe_cmd),
    .imm          (imm),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .s            (s),
    .status_in    (status_in),
    .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24),
    .pc           (pc),
    .val_rn       (val_rn),
    .val_rm       (val_rm),
    .alu_result   (alu_result),
    .br_addr      (br_addr),
    .status_q     (status_q),
    .stall        (stall)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  model_st = 4'b0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  function automatic logic [31:0] m_val2(input logic [11:0] so, input logic [31:0] rm,
                                         input logic im, input logic mem);
    logic [63:0] d;
    int          amt;
    if (mem) return {20'b0, so};
    if (im) begin
      d = {24'b0, so[7:0], 24'b0, so[7:0]} >> (2 * int'(so[11:8]));
      return d[31:0];
    end
    amt = int'(so[11:7]);
    case (so[6:5])
      2'b00: begin d = {32'b0, rm} << amt; return d[31:0]; end
      2'b01: return rm >> amt;
      2'b10: return rm[31] ? ~((~rm) >> amt) : (rm >> amt);
      default: begin d = {rm, rm} >> amt; return d[31:0]; end
    endcase
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                input logic [31:0] v2, input logic [3:0] st,
                                output logic [31:0] res, output logic [3:0] fl,
                                output logic wr);
    longint au, bu, as, bs, us, ss;
    longint cin;
    logic   c, v;
    au  = longint'({32'b0, rn});
    bu  = longint'({32'b0, v2});
    as  = longint'($signed(rn));
    bs  = longint'($signed(v2));
    cin = st[1] ? 64'd1 : 64'd0;
    c   = st[1];
    v   = st[0];
    wr  = 1'b1;
    res = 32'd0;
    case (cmd)
      4'b0001: res = v2;
      4'b1001: res = ~v2;
      4'b0010, 4'b0011: begin
        if (cmd == 4'b0010) cin = 0;
        us  = au + bu + cin;
        ss  = as + bs + cin;
        res = rn + v2 + 32'(cin);
        c   = (us >= 64'sd4294967296);
        v   = (ss > S_MAX) || (ss < S_MIN);
      end
      4'b0100, 4'b0101: begin
        // borrow in: none for SUB, !C for SBC
        cin = (cmd == 4'b0100) ? 64'd0 : (st[1] ? 64'd0 : 64'd1);
        ss  = as - bs - cin;
        res = rn - v2 - 32'(cin);
        c   = (au >= bu + cin);
        v   = (ss > S_MAX) || (ss < S_MIN);
      end
      4'b0110: res = rn & v2;
      4'b0111: res = rn | v2;
      4'b1000: res = rn ^ v2;
      default: wr = 1'b0;
    endcase
    fl = {res[31], res == 32'd0, c, v};
  endfunction

  function automatic logic [31:0] m_br(input logic [31:0] p, input logic [23:0] off);
    longint o;
    o = longint'(off);
    if (off[23]) o = o - 64'sd16777216;
    return p + 32'(o * 4);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic im, input logic r_en, input logic w_en, input logic s_b,
                        input logic [3:0] st_in, input logic [11:0] so,
                        input logic [31:0] pc_v, input logic [23:0] off);
    logic [31:0] v2, res;
    logic [3:0]  fl;
    logic        wr;
    @(negedge clk);
    exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = im; mem_r_en = r_en; mem_w_en = w_en;
    s = s_b; status_in = st_in; shift_operand = so; pc = pc_v; signed_imm_24 = off;
    v2 = m_val2(so, rm, im, r_en | w_en);
    m_alu(cmd, rn, v2, st_in, res, fl, wr);
    exp_q.push_back(res);
    exp_q.push_back(m_br(pc_v, off));
    #1;
    check("alu_result", alu_result, exp_q.pop_front());
    check("br_addr", br_addr, exp_q.pop_front());
    check("stall_alu", {31'b0, stall}, 32'd0);
    if (s_b && wr) model_st = fl;
    @(posedge clk);
    #1;
    check("status_q", {28'b0, status_q}, {28'b0, model_st});
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s_b,
                         input logic [3:0] st_in);
    int          cycles;
    logic [63:0] full;
    @(negedge clk);
    exe_cmd = CMD_MUL; val_rn = a; val_rm = b; s = s_b; status_in = st_in;
    imm = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; shift_operand = 12'($urandom);
    #1;
    cycles = 0;
    while (stall === 1'b1 && cycles < 200) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check("mul_stall_cycles", 32'(cycles), 32'(MUL_STALLS));
    full = {32'b0, a} * {32'b0, b};
    exp_q.push_back(full[31:0]);
    check("mul_result", alu_result, exp_q.pop_front());
    if (s_b) model_st = {full[31], full[31:0] == 32'd0, st_in[1], st_in[0]};
    @(posedge clk);
    #1;
    check("mul_status", {28'b0, status_q}, {28'b0, model_st});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] cmd_tab[12];

  initial begin
    cmd_tab = '{CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC,
                CMD_AND, CMD_ORR, CMD_EOR, CMD_NOP, 4'b1011, 4'b1111};
    rst = 1'b1; exe_cmd = CMD_MUL; imm = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    s = 1'b0; status_in = 4'b0; shift_operand = 12'b0; signed_imm_24 = 24'b0;
    pc = 32'b0; val_rn = 32'd3; val_rm = 32'd4;

    // Reset state, with a MUL presented while reset is held
    repeat (3) @(negedge clk);
    #1;
    check("rst_status", {28'b0, status_q}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    exe_cmd = CMD_NOP;
    @(negedge clk);
    rst = 1'b0;

    // 1. ADD with flags: signed overflow into the sign bit
    do_alu(CMD_ADD, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 12'h001, 32'h0, 24'h0);
    check("t1_status", {28'b0, status_q}, 32'b1001);

    // 2. SUB equal operands: zero, no borrow
    do_alu(CMD_SUB, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'h000, 32'h0, 24'h0);
    check("t2_status", {28'b0, status_q}, 32'b0110);

    // 3. Rotated immediate and backward branch
    do_alu(CMD_MOV, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 12'h4FF, 32'h100, 24'hFFFFFE);
    check("t3_mov", alu_result, 32'hFF000000);
    check("t3_br", br_addr, 32'h000000F8);

    // 4. ASR #4 and ROR #0 on a register operand
    do_alu(CMD_MOV, 32'h0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 12'h240, 32'h0, 24'h0);
    check("t4_asr", alu_result, 32'hF8000000);
    do_alu(CMD_MOV, 32'h0, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 12'h060, 32'h0, 24'h0);
    check("t4_ror0", alu_result, 32'h80000001);

    // Load/store address: raw 12-bit offset overrides imm/shift decoding
    do_alu(CMD_ADD, 32'h1000, 32'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 12'hF3C, 32'h0, 24'h0);
    check("ldr_addr", alu_result, 32'h1F3C);

    // Randomized ALU operations
    for (int i = 0; i < 60; i++) begin
      logic mem_b;
      mem_b = ($urandom_range(0, 7) == 0);
      do_alu(cmd_tab[$urandom_range(0, 11)], $urandom, $urandom, 1'($urandom),
             mem_b & 1'($urandom), mem_b, 1'($urandom), 4'($urandom), 12'($urandom),
             $urandom, 24'($urandom));
    end

    // 5. MUL timing and product, then back-to-back
    run_mul(32'h12345, 32'h6789, 1'b1, 4'b0011);
    run_mul(32'h12345, 32'h6789, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      run_mul($urandom, $urandom, 1'($urandom), 4'($urandom));
    end

    // 6. Reset in the middle of a MUL
    do_alu(CMD_SUB, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'h000, 32'h0, 24'h0);
    @(negedge clk);
    exe_cmd = CMD_MUL; val_rn = 32'hDEAD; val_rm = 32'hBEEF; s = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_st = 4'b0000;
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    check("rst_mid_status", {28'b0, status_q}, 32'd0);
    exe_cmd = CMD_NOP;
    @(negedge clk);
    rst = 1'b0;
    run_mul(32'h0000ABCD, 32'h00012345, 1'b1, 4'b0000);

    // Pipeline resumes normally after a MUL
    do_alu(CMD_ORR, 32'h0F0, 32'h00F, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 12'h000, 32'h40, 24'h000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
